// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - divider state encodings and handshake constants
package div_unit_pkg;

   typedef enum logic [1:0] {
      DIV_FREE    = 2'b00,
      DIV_BY_ZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } div_state_t;

   localparam logic DIV_START        = 1'b1;
   localparam logic DIV_STOP         = 1'b0;
   localparam logic DIV_RESULT_READY = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle restoring divider for DIV/DIVU
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);

   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

   div_state_t       state, state_next;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvd;     // dividend magnitude shifting out, quotient shifting in
   logic [WIDTH-1:0] dsr;
   logic             sign1, sign2, sgn_op;

   logic [WIDTH:0]   shifted, trial;
   logic             q_bit;
   logic [WIDTH-1:0] q_fix, r_fix;
   logic             accept;

   assign accept  = (start_i == DIV_START) && !annul_i;
   assign shifted = {rem, dvd[WIDTH-1]};
   assign trial   = shifted - {1'b0, dsr};
   assign q_bit   = ~trial[WIDTH];
   assign q_fix   = (sgn_op && (sign1 ^ sign2)) ? (~dvd + ONE) : dvd;
   assign r_fix   = (sgn_op && sign1) ? (~rem + ONE) : rem;

   always_ff @(posedge clk) begin
      if (rst) state <= DIV_FREE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         DIV_FREE: begin
            if (accept) state_next = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
         end
         DIV_BY_ZERO: state_next = DIV_END;
         DIV_ON: begin
            if (annul_i)              state_next = DIV_FREE;
            else if (cnt == LAST_CNT) state_next = DIV_END;
         end
         DIV_END: begin
            if (start_i == DIV_STOP || annul_i) state_next = DIV_FREE;
         end
         default: state_next = DIV_FREE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         rem      <= '0;
         dvd      <= '0;
         dsr      <= '0;
         sign1    <= 1'b0;
         sign2    <= 1'b0;
         sgn_op   <= 1'b0;
         result_o <= '0;
         ready_o  <= DIV_RESULT_NOT_READY;
      end else begin
         case (state)
            DIV_FREE: begin
               ready_o <= DIV_RESULT_NOT_READY;
               if (accept && opdata2_i != '0) begin
                  dvd    <= (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + ONE) : opdata1_i;
                  dsr    <= (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + ONE) : opdata2_i;
                  sign1  <= opdata1_i[WIDTH-1];
                  sign2  <= opdata2_i[WIDTH-1];
                  sgn_op <= signed_div_i;
                  cnt    <= '0;
                  rem    <= '0;
               end
            end
            DIV_BY_ZERO: begin
               result_o <= '0;
               ready_o  <= DIV_RESULT_READY;
            end
            DIV_ON: begin
               if (!annul_i) begin
                  if (cnt != LAST_CNT) begin
                     rem <= q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                     dvd <= {dvd[WIDTH-2:0], q_bit};
                     cnt <= cnt + 1'b1;
                  end else begin
                     result_o <= {r_fix, q_fix};
                     ready_o  <= DIV_RESULT_READY;
                  end
               end
            end
            DIV_END: begin
               if (start_i == DIV_STOP || annul_i) ready_o <= DIV_RESULT_NOT_READY;
            end
            default: ready_o <= DIV_RESULT_NOT_READY;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit at WIDTH=32 and WIDTH=8
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div, start, annul;
   logic [31:0] op1, op2;
   logic [63:0] result;
   logic        ready;

   logic        signed_div8, start8, annul8;
   logic [7:0]  op1_8, op2_8;
   logic [15:0] result8;
   logic        ready8;

   int vectors = 0;
   int miscompares = 0;

   logic [63:0] sb_q[$];
   int          lat_q[$];

   always #5 clk = ~clk;

   div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .signed_div_i(signed_div),
      .opdata1_i(op1), .opdata2_i(op2), .start_i(start), .annul_i(annul),
      .result_o(result), .ready_o(ready)
   );

   div_unit #(.WIDTH(8), .CNT_W(4)) dut8 (
      .clk(clk), .rst(rst), .signed_div_i(signed_div8),
      .opdata1_i(op1_8), .opdata2_i(op2_8), .start_i(start8), .annul_i(annul8),
      .result_o(result8), .ready_o(ready8)
   );

   function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb, sq, sr;
      logic [31:0] uq, ur;
      if (sgn) begin
         sa = a; sb = b;
         sq = sa / sb; sr = sa % sb;
         return {sr, sq};
      end
      uq = a / b; ur = a % b;
      return {ur, uq};
   endfunction

   // n counts edges from the one that samples start_i (edge 1) until ready_o is seen
   task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int exp_edges, input string name);
      int n;
      logic [63:0] exp_r;
      int exp_l;
      @(negedge clk);
      signed_div = sgn; op1 = a; op2 = b; start = 1'b1;
      sb_q.push_back(exp);
      lat_q.push_back(exp_edges);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            op1 = $urandom; op2 = $urandom; signed_div = ~sgn;
         end
      end while (!ready && n < 100);
      exp_r = sb_q.pop_front();
      exp_l = lat_q.pop_front();
      vectors++;
      if (ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s timeout: ready=%b after %0d edges, required 1", name, ready, n);
      end else if (n != exp_l) begin
         miscompares++;
         $display("FAIL %s latency: got %0d edges, required %0d", name, n, exp_l);
      end
      vectors++;
      if (result !== exp_r) begin
         miscompares++;
         $display("FAIL %s result: got %h, required %h", name, result, exp_r);
      end
      @(negedge clk);
      vectors++;
      if (ready !== 1'b1 || result !== exp_r) begin
         miscompares++;
         $display("FAIL %s hold: ready=%b result=%h, required 1 %h", name, ready, result, exp_r);
      end
      start = 1'b0;
      @(negedge clk);
      vectors++;
      if (ready !== 1'b0) begin
         miscompares++;
         $display("FAIL %s release: ready=%b, required 0", name, ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
      start8 = 1'b0; annul8 = 1'b0; signed_div8 = 1'b0; op1_8 = '0; op2_8 = '0;
      repeat (3) @(negedge clk);
      vectors++;
      if (ready !== 1'b0 || result !== 64'd0) begin
         miscompares++;
         $display("FAIL reset: ready=%b result=%h, required 0 0", ready, result);
      end
      vectors++;
      if (ready8 !== 1'b0 || result8 !== 16'd0) begin
         miscompares++;
         $display("FAIL reset8: ready=%b result=%h, required 0 0", ready8, result8);
      end
      rst = 1'b0;
   endtask

   task automatic test_unsigned();
      run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, "udiv_100_7");
   endtask

   task automatic test_signed();
      run_div(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, "sdiv_m7_2");
      run_div(1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 34, "sdiv_7_m2");
      run_div(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, {32'hFFFFFFFF, 32'h00000003}, 34, "sdiv_m7_m2");
      run_div(1'b0, 32'hFFFFFFF9, 32'd2, {32'd1, 32'h7FFFFFFC}, 34, "udiv_big_2");
   endtask

   task automatic test_by_zero();
      run_div(1'b0, 32'd1234, 32'd0, 64'd0, 2, "div_by_zero");
   endtask

   task automatic test_annul();
      int highs = 0;
      @(negedge clk);
      signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
      repeat (11) @(negedge clk);
      annul = 1'b1; start = 1'b0;
      @(negedge clk);
      annul = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (ready) highs++;
      end
      vectors++;
      if (highs != 0) begin
         miscompares++;
         $display("FAIL annul: ready high for %0d cycles, required 0", highs);
      end
      run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, "after_annul_9_3");
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      signed_div = 1'b0; op1 = 32'd12345; op2 = 32'd7; start = 1'b1;
      repeat (21) @(negedge clk);
      rst = 1'b1; start = 1'b0;
      @(negedge clk);
      vectors++;
      if (ready !== 1'b0 || result !== 64'd0) begin
         miscompares++;
         $display("FAIL reset_mid: ready=%b result=%h, required 0 0", ready, result);
      end
      rst = 1'b0;
      run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 34, "sdiv_min_m1");
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      logic        s;
      for (int i = 0; i < 6; i++) begin
         s = i[0];
         a = $urandom;
         b = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (b == 0) b = 32'd5;
         if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
         run_div(s, a, b, model(s, a, b), 34, "random");
      end
   endtask

   task automatic test_width8();
      int n = 0;
      @(negedge clk);
      signed_div8 = 1'b0; op1_8 = 8'd200; op2_8 = 8'd3; start8 = 1'b1;
      sb_q.push_back({48'd0, 8'd2, 8'd66});
      lat_q.push_back(10);
      do begin
         @(negedge clk);
         n++;
      end while (!ready8 && n < 40);
      vectors++;
      if (ready8 !== 1'b1 || n != lat_q.pop_front()) begin
         miscompares++;
         $display("FAIL w8 latency: ready=%b edges=%0d, required 1 10", ready8, n);
      end
      vectors++;
      if ({48'd0, result8} !== sb_q.pop_front()) begin
         miscompares++;
         $display("FAIL w8 result: got %h, required %h", result8, {8'd2, 8'd66});
      end
      start8 = 1'b0;
      @(negedge clk);
      vectors++;
      if (ready8 !== 1'b0) begin
         miscompares++;
         $display("FAIL w8 release: ready=%b, required 0", ready8);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_by_zero();
      test_annul();
      test_reset_mid();
      test_random();
      test_width8();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
